// File: rtl/button_event_decoder_if.sv
// Signal bundle between the debounced button source and the event decoder.
// The slave modport is the decoder; the master modport is whoever drives clean and consumes the events.
interface button_event_decoder_if;
    logic       clean;
    logic       held;
    logic       press_pulse;
    logic       release_pulse;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic [7:0] press_count;

    modport master (
        output clean,
        input  held,
        input  press_pulse,
        input  release_pulse,
        input  short_press,
        input  long_press,
        input  double_click,
        input  press_count
    );

    modport slave (
        input  clean,
        output held,
        output press_pulse,
        output release_pulse,
        output short_press,
        output long_press,
        output double_click,
        output press_count
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short/long/double-click pulses
// and keeps a wrapping count of presses.
module button_event_decoder #(
    parameter int unsigned LONG_CYCLES = 16,
    parameter int unsigned DBL_GAP     = 8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    button_event_decoder_if.slave  btn
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_LONG,
        S_WAIT,
        S_PRESS2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DBL_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic             clean_d;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] gap_cnt;
    logic [CNT_W-1:0] hold_nxt;
    logic [CNT_W-1:0] gap_nxt;
    logic             rise;
    logic             fall;

    logic             press_r;
    logic             release_r;
    logic             short_r;
    logic             long_r;
    logic             dbl_r;
    logic [7:0]       count_r;

    always_comb begin
        rise     = btn.clean & ~clean_d;
        fall     = ~btn.clean & clean_d;
        hold_nxt = hold_cnt + CNT_ONE;
        gap_nxt  = gap_cnt + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            clean_d   <= 1'b0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
            dbl_r     <= 1'b0;
            count_r   <= '0;
        end else begin
            clean_d   <= btn.clean;
            press_r   <= rise;
            release_r <= fall;
            short_r   <= 1'b0;
            long_r    <= 1'b0;
            dbl_r     <= 1'b0;
            if (rise) begin
                count_r <= count_r + 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state    <= S_PRESS1;
                        hold_cnt <= CNT_ONE;
                    end
                end
                S_PRESS1: begin
                    // clean_d is always high here, so a low sample is the fall
                    if (btn.clean) begin
                        hold_cnt <= hold_nxt;
                        if (hold_nxt == LONG_LIM) begin
                            long_r <= 1'b1;
                            state  <= S_LONG;
                        end
                    end else begin
                        gap_cnt <= CNT_ONE;
                        if (GAP_LIM == CNT_ONE) begin
                            short_r <= 1'b1;
                            state   <= S_IDLE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_LONG: begin
                    if (fall) begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (rise) begin
                        dbl_r <= 1'b1;
                        state <= S_PRESS2;
                    end else if (!btn.clean) begin
                        gap_cnt <= gap_nxt;
                        if (gap_nxt == GAP_LIM) begin
                            short_r <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_PRESS2: begin
                    if (fall) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign btn.held          = clean_d;
    assign btn.press_pulse   = press_r;
    assign btn.release_pulse = release_r;
    assign btn.short_press   = short_r;
    assign btn.long_press    = long_r;
    assign btn.double_click  = dbl_r;
    assign btn.press_count   = count_r;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the switch debouncer; consumes its debounced level output.
- Classifies each press into single-cycle events: press, release, short press, long press and double click.
- Also maintains a press counter.
- Feeds the lab's control logic, which acts only on these one-cycle pulses, never on the raw level.

Parameters:
LONG_CYCLES, 16, consecutive high samples of clean that make a long press (legal range 2 .. 2^CNT_W-1)
DBL_GAP, 8, consecutive low samples after a release before the press is classified short (legal range 1 .. 2^CNT_W-1)
CNT_W, 8, width of the internal hold and gap counters

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous reset, active-high
clean  input  1  debounced button level, synchronous to clk
held  output  1  registered copy of clean (one-cycle delay)
press_pulse  output  1  one-cycle pulse on each 0->1 transition of clean
release_pulse  output  1  one-cycle pulse on each 1->0 transition of clean
short_press  output  1  one-cycle pulse when a press is classified as short
long_press  output  1  one-cycle pulse when a hold reaches LONG_CYCLES
double_click  output  1  one-cycle pulse when a second press starts inside the gap window
press_count  output  8  number of rises seen; wraps 255->0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk and rst).
- Reset (rst=1 at a clock edge):
  - All outputs go to 0; press_count goes to 0.
  - Internal clean_d goes to 0; FSM goes to IDLE; counters go to 0.
  - rst overrides all other activity, including reset asserted mid-press or mid-gap.
- Edge detection:
  - rise = clean & ~clean_d; fall = ~clean & clean_d; clean_d <= clean every cycle; held = clean_d.
  - If clean is high at the first edge after reset releases, that edge counts as a rise.
- Output timing:
  - Every output is registered. An event sampled at edge k is visible from edge k until edge k+1 (latency 1 clock).
  - Every pulse output is high for exactly one cycle.
- press_pulse / release_pulse: fire on every rise / fall, in every state. press_count increments on every rise.
- FSM states: IDLE, PRESS1, LONG, WAIT, PRESS2.
  - IDLE: on rise, go to PRESS1 with hold_cnt <= 1.
  - PRESS1:
    - If clean=1, hold_cnt++. When the incremented value equals LONG_CYCLES, pulse long_press and go to LONG.
    - On fall, go to WAIT with gap_cnt <= 1.
  - LONG: on fall, go to IDLE. No short_press or double_click is ever issued for a long press.
  - WAIT:
    - On rise, pulse double_click (same cycle as press_pulse) and go to PRESS2.
    - Else if clean=0, gap_cnt++. When the incremented value equals DBL_GAP, pulse short_press and go to IDLE. With DBL_GAP=1, short_press fires on the fall sample itself.
  - PRESS2: on fall, go to IDLE. The second press of a double click is never classified as short or long, whatever its length.
- Boundaries:
  - hold_cnt counts only high samples and gap_cnt counts only low samples, so a rise and gap expiry can never coincide.
  - A rise on the cycle after the DBL_GAP-th low sample lands in IDLE and starts a new PRESS1 sequence, not a double click.
  - Counters never exceed their limits, because the FSM leaves the state on reaching them.
  - At most one of short_press, long_press and double_click is high in any cycle.

Test Plan:
- Reset with clean=0 for 3 cycles -> all outputs 0, press_count=0, and outputs stay 0 for 10 idle cycles after rst drops.
- clean high 5 samples, then low -> press_pulse 1 cycle after the first high sample; release_pulse 1 cycle after the first low sample; short_press exactly 7 cycles after release_pulse; long_press never fires; press_count=1.
- clean high 20 samples, then low 20 -> long_press once, visible 15 cycles after press_pulse; release_pulse on release; no short_press or double_click.
- clean high 3, low 4, high 3, low 20 -> double_click coincides with the second press_pulse; no short_press; press_count=2.
- clean high 3, low exactly 8, high 3, low 20 -> short_press is visible on the edge after the 8th low sample; a second short_press follows the second press; double_click never fires; press_count=2.
- rst pulsed for 1 cycle while in PRESS1 with clean held high -> outputs clear; press_pulse fires on the first edge after reset releases; press_count=1; long_press fires once LONG_CYCLES high samples have been seen after reset.
